// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter in front of the test memory bus.
// Out-of-window or read+write requests are completed locally and latched as errors.
module mips_bus_arbiter #(
  parameter logic [31:0] BASE   = 32'hBFC00000,
  parameter logic [31:0] SIZE   = 32'h00008000,
  parameter int          DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [31:0]       m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [31:0]       s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [3:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              err,
  output logic [31:0]       err_addr
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ERR0, ERR1} state_t;

  state_t      state, state_nxt;
  logic        last_srv, last_nxt;
  logic        set_err;
  logic [31:0] blk_addr;
  logic        m0_req, m1_req, pick1, bad;
  logic [31:0] win_addr;
  logic        win_rd, win_wr;

  // Unsigned window test; BASE+SIZE is assumed not to wrap.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= BASE) && ((addr - BASE) < SIZE);
  endfunction

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  always_comb begin
    state_nxt      = state;
    last_nxt       = last_srv;
    set_err        = 1'b0;
    blk_addr       = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    // On a tie the master not served last wins.
    pick1          = m1_req && (!m0_req || !last_srv);
    win_addr       = pick1 ? m1_address : m0_address;
    win_rd         = pick1 ? m1_read : m0_read;
    win_wr         = pick1 ? m1_write : m0_write;
    bad            = !in_window(win_addr) || (win_rd && win_wr);

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          if (pick1) state_nxt = bad ? ERR1 : GNT1;
          else       state_nxt = bad ? ERR0 : GNT0;
        end
      end
      GNT0: begin
        s_address    = m0_address;
        s_read       = m0_read;
        s_write      = m0_write;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        if (!s_waitrequest) begin
          m0_waitrequest = 1'b0;
          m0_readdata    = s_readdata;
          last_nxt       = 1'b0;
          state_nxt      = IDLE;
        end
      end
      GNT1: begin
        s_address    = m1_address;
        s_read       = m1_read;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        if (!s_waitrequest) begin
          m1_waitrequest = 1'b0;
          m1_readdata    = s_readdata;
          last_nxt       = 1'b1;
          state_nxt      = IDLE;
        end
      end
      ERR0: begin
        m0_waitrequest = 1'b0;
        last_nxt       = 1'b0;
        set_err        = 1'b1;
        blk_addr       = m0_address;
        state_nxt      = IDLE;
      end
      ERR1: begin
        m1_waitrequest = 1'b0;
        last_nxt       = 1'b1;
        set_err        = 1'b1;
        blk_addr       = m1_address;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_srv <= 1'b1;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_nxt;
      last_srv <= last_nxt;
      if (set_err) begin
        err <= 1'b1;
        if (!err) err_addr <= blk_addr;
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Randomized bench for mips_bus_arbiter: two random masters and a random-wait slave,
// compared every cycle against a transaction-ownership reference model.
module tb_mips_bus_arbiter;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam logic [31:0] SIZE = 32'h00008000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic        err;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  mips_bus_arbiter #(.BASE(BASE), .SIZE(SIZE), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = longint'(a);
    lo = longint'(BASE);
    hi = lo + longint'(SIZE);
    return (la >= lo) && (la < hi);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: pick_addr = BASE + ($urandom_range(0, 32'h7FFF) & 32'hFFFF_FFFC);
      4: pick_addr = BASE;
      5: pick_addr = BASE + SIZE - 1;
      6: pick_addr = BASE + SIZE;
      7: pick_addr = BASE - 1;
      8: pick_addr = 32'h0000_0004;
      default: pick_addr = $urandom;
    endcase
  endfunction

  // Master-side stimulus: a held request per master until it completes.
  bit          act [2];
  logic [31:0] ma [2], mwd [2];
  logic [3:0]  mbe [2];
  logic        mr [2], mw [2];

  // Reference model: who owns the bus, whether that access is blocked, and arbitration history.
  int          own;
  bit          own_blk;
  int          last;
  bit          e;
  logic [31:0] ea;
  int          n_own, n_last;
  bit          n_blk, n_e;
  logic [31:0] n_ea;
  bit          done [2];

  logic [31:0] x_rd [2];
  logic        x_w [2];
  logic [31:0] x_sa, x_swd;
  logic        x_sr, x_sw;
  logic [3:0]  x_sbe;

  task automatic model_reset();
    own = -1; own_blk = 0; last = 1; e = 0; ea = '0;
  endtask

  task automatic drive();
    m0_address = ma[0]; m0_writedata = mwd[0]; m0_byteenable = mbe[0];
    m0_read = act[0] & mr[0]; m0_write = act[0] & mw[0];
    m1_address = ma[1]; m1_writedata = mwd[1]; m1_byteenable = mbe[1];
    m1_read = act[1] & mr[1]; m1_write = act[1] & mw[1];
  endtask

  initial begin
    reset = 1'b1;
    s_waitrequest = 1'b1;
    s_readdata = '0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; ma[n] = '0; mwd[n] = '0; mbe[n] = '0; mr[n] = 0; mw[n] = 0;
    end
    drive();
    model_reset();
    @(posedge clk); #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      reset = (cyc < 2) || (cyc >= 1500 && cyc < 1502) || ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && (cyc == 2 || $urandom_range(0, 2) != 0)) begin
          act[n] = 1;
          ma[n]  = (cyc == 2) ? BASE + 32'h10 : pick_addr();
          mwd[n] = $urandom;
          mbe[n] = 4'($urandom_range(0, 15));
          case ($urandom_range(0, 9))
            0:       begin mr[n] = 1; mw[n] = 1; end
            1, 2, 3: begin mr[n] = 0; mw[n] = 1; end
            default: begin mr[n] = 1; mw[n] = 0; end
          endcase
        end
      end
      drive();
      s_waitrequest = reset ? 1'b1 : ($urandom_range(0, 2) == 0);
      s_readdata    = $urandom;
      #3;

      // Expected outputs from the model's view of bus ownership.
      x_w[0] = 1; x_w[1] = 1; x_rd[0] = '0; x_rd[1] = '0;
      x_sa = '0; x_sr = 0; x_sw = 0; x_swd = '0; x_sbe = '0;
      done[0] = 0; done[1] = 0;
      n_own = own; n_blk = own_blk; n_last = last; n_e = e; n_ea = ea;
      if (own < 0) begin
        if (act[0] || act[1]) begin
          if (act[0] && act[1]) n_own = 1 - last;
          else                  n_own = act[0] ? 0 : 1;
          n_blk = !legal(ma[n_own]) || (mr[n_own] && mw[n_own]);
        end
      end else if (own_blk) begin
        x_w[own] = 0;
        done[own] = 1;
        n_last = own; n_own = -1;
        if (!e) n_ea = ma[own];
        n_e = 1;
      end else begin
        x_sa = ma[own]; x_sr = mr[own]; x_sw = mw[own]; x_swd = mwd[own]; x_sbe = mbe[own];
        if (!s_waitrequest) begin
          x_w[own] = 0; x_rd[own] = s_readdata;
          done[own] = 1;
          n_last = own; n_own = -1;
        end
      end

      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(x_w[0]));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(x_w[1]));
      chk("m0_readdata", m0_readdata, x_rd[0]);
      chk("m1_readdata", m1_readdata, x_rd[1]);
      chk("s_address", s_address, x_sa);
      chk("s_read", 32'(s_read), 32'(x_sr));
      chk("s_write", 32'(s_write), 32'(x_sw));
      chk("s_writedata", s_writedata, x_swd);
      chk("s_byteenable", 32'(s_byteenable), 32'(x_sbe));
      chk("err", 32'(err), 32'(e));
      chk("err_addr", err_addr, ea);

      @(posedge clk); #1;
      if (reset) model_reset();
      else begin
        own = n_own; own_blk = n_blk; last = n_last; e = n_e; ea = n_ea;
      end
      for (int n = 0; n < 2; n++) if (done[n]) act[n] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
